// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and sizing helpers for the vector writeback stage
package wb_pkg;

  typedef enum logic [1:0] {
    WB_MEM  = 2'd0,
    WB_ALU  = 2'd1,
    WB_IMM  = 2'd2,
    WB_NONE = 2'd3
  } wb_src_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } wb_state_e;

  // A single-word memory still needs one index bit to keep port widths legal.
  function automatic int mem_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/vec_data_mem.sv
// rtl/vec_data_mem.sv - banked vector data memory: one read-first sync read port, one lane-masked write port
module vec_data_mem
  import wb_pkg::*;
#(
  parameter int vecSize      = 4,
  parameter int registerSize = 8,
  parameter int DEPTH        = 32,
  parameter int AW           = mem_addr_width(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  rd_en,
  input  logic [AW-1:0]                         rd_addr,
  output logic [vecSize-1:0][registerSize-1:0]  rd_data,
  input  logic                                  wr_en,
  input  logic [AW-1:0]                         wr_addr,
  input  logic [vecSize-1:0]                    wr_mask,
  input  logic [vecSize-1:0][registerSize-1:0]  wr_data
);

  logic [vecSize-1:0][registerSize-1:0] mem [DEPTH];

  // Each lane is its own bank, so a partial store only touches the enabled lanes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < vecSize; i++) begin
        if (wr_mask[i]) begin
          mem[wr_addr][i] <= wr_data[i];
        end
      end
    end
  end

  // Non-blocking read of the pre-edge contents gives read-first behaviour on collisions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/stage_writeback_pipe.sv
// rtl/stage_writeback_pipe.sv - two-stage vector writeback pipe with banked data memory
// and a post-reset memory clear sweep.
module stage_writeback_pipe
  import wb_pkg::*;
#(
  parameter int vecSize      = 4,
  parameter int registerSize = 8,
  parameter int DEPTH        = 32,
  parameter int REG_ADDR_W   = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  inValid,
  output logic                                  inReady,
  input  logic                                  memWrite,
  input  logic                                  regWrite,
  input  logic [1:0]                            writeRegFrom,
  input  logic [vecSize-1:0]                    laneMask,
  input  logic [registerSize-1:0]               address,
  input  logic [registerSize-1:0]               imm,
  input  logic [REG_ADDR_W-1:0]                 destReg,
  input  logic [vecSize-1:0][registerSize-1:0]  writeData,
  input  logic [vecSize-1:0][registerSize-1:0]  aluResult,
  output logic                                  outValid,
  input  logic                                  outReady,
  output logic [vecSize-1:0][registerSize-1:0]  writeBackData,
  output logic                                  rfWriteEnable,
  output logic [REG_ADDR_W-1:0]                 rfDest,
  output logic                                  addrError
);

  localparam int AW = mem_addr_width(DEPTH);
  localparam logic [registerSize:0] DEPTH_LIM = (registerSize+1)'(DEPTH);

  typedef logic [vecSize-1:0][registerSize-1:0] vec_t;

  wb_state_e state, state_next;
  logic [AW-1:0] clear_addr;
  logic          clear_last;
  logic          clear_we;

  logic accept;
  logic stall;
  logic in_range;

  logic                  mem_wr_en;
  logic [AW-1:0]         mem_wr_addr;
  logic [vecSize-1:0]    mem_wr_mask;
  vec_t                  mem_wr_data;
  vec_t                  mem_rd_data;

  logic                    s1_valid;
  logic                    s1_reg_write;
  logic                    s1_addr_err;
  wb_src_e                 s1_src;
  logic [REG_ADDR_W-1:0]   s1_dest;
  vec_t                    s1_alu;
  logic [registerSize-1:0] s1_imm;
  vec_t                    s1_result;

  logic                  s2_valid;
  logic                  s2_reg_write;
  logic                  s2_addr_err;
  wb_src_e               s2_src;
  logic [REG_ADDR_W-1:0] s2_dest;
  vec_t                  s2_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clear_last) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    inReady  = 1'b0;
    clear_we = 1'b0;
    case (state)
      CLEAR:   clear_we = 1'b1;
      RUN:     inReady  = ~stall;
      default: inReady  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clear_addr <= '0;
    end else if (clear_we && !clear_last) begin
      clear_addr <= clear_addr + AW'(1);
    end
  end

  assign clear_last = (clear_addr == AW'(DEPTH - 1));

  assign accept   = inValid & inReady;
  assign stall    = s2_valid & ~outReady;
  assign in_range = ({1'b0, address} < DEPTH_LIM);

  // The sweep owns the write port while clearing; ops cannot be accepted then.
  assign mem_wr_en   = clear_we | (accept & memWrite & in_range);
  assign mem_wr_addr = clear_we ? clear_addr : address[AW-1:0];
  assign mem_wr_mask = clear_we ? {vecSize{1'b1}} : laneMask;
  assign mem_wr_data = clear_we ? '0 : writeData;

  vec_data_mem #(
    .vecSize      (vecSize),
    .registerSize (registerSize),
    .DEPTH        (DEPTH),
    .AW           (AW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (accept),
    .rd_addr (address[AW-1:0]),
    .rd_data (mem_rd_data),
    .wr_en   (mem_wr_en),
    .wr_addr (mem_wr_addr),
    .wr_mask (mem_wr_mask),
    .wr_data (mem_wr_data)
  );

  // The memory read register only moves on accept, so it stays aligned with s1 through stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid     <= 1'b0;
      s1_reg_write <= 1'b0;
      s1_addr_err  <= 1'b0;
      s1_src       <= WB_NONE;
      s1_dest      <= '0;
      s1_alu       <= '0;
      s1_imm       <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_reg_write <= regWrite;
        s1_addr_err  <= ~in_range;
        s1_src       <= wb_src_e'(writeRegFrom);
        s1_dest      <= destReg;
        s1_alu       <= aluResult;
        s1_imm       <= imm;
      end
    end
  end

  always_comb begin
    s1_result = '0;
    case (s1_src)
      WB_MEM:  if (!s1_addr_err) s1_result = mem_rd_data;
      WB_ALU:  s1_result = s1_alu;
      WB_IMM:  s1_result = {vecSize{s1_imm}};
      default: s1_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_valid     <= 1'b0;
      s2_reg_write <= 1'b0;
      s2_addr_err  <= 1'b0;
      s2_src       <= WB_NONE;
      s2_dest      <= '0;
      s2_data      <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_reg_write <= s1_reg_write;
        s2_addr_err  <= s1_addr_err;
        s2_src       <= s1_src;
        s2_dest      <= s1_dest;
        s2_data      <= s1_result;
      end
    end
  end

  assign outValid      = s2_valid;
  assign writeBackData = s2_data;
  assign rfWriteEnable = s2_valid & s2_reg_write & (s2_src != WB_NONE);
  assign rfDest        = s2_dest;
  assign addrError     = s2_addr_err;

endmodule

// File: tb/tb_stage_writeback_pipe.sv
// tb/tb_stage_writeback_pipe.sv - bench for stage_writeback_pipe: queue model plus directed literals
module tb_stage_writeback_pipe;

  localparam int VS    = 4;
  localparam int RS    = 8;
  localparam int DEPTH = 32;
  localparam int RW    = 4;
  localparam int DW    = VS * RS;

  logic          clk = 1'b0;
  logic          reset;
  logic          inValid;
  logic          inReady;
  logic          memWrite;
  logic          regWrite;
  logic [1:0]    writeRegFrom;
  logic [VS-1:0] laneMask;
  logic [RS-1:0] address;
  logic [RS-1:0] imm;
  logic [RW-1:0] destReg;
  logic [DW-1:0] writeData;
  logic [DW-1:0] aluResult;
  logic          outValid;
  logic          outReady;
  logic [DW-1:0] writeBackData;
  logic          rfWriteEnable;
  logic [RW-1:0] rfDest;
  logic          addrError;

  always #5 clk = ~clk;

  stage_writeback_pipe #(
    .vecSize      (VS),
    .registerSize (RS),
    .DEPTH        (DEPTH),
    .REG_ADDR_W   (RW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inValid       (inValid),
    .inReady       (inReady),
    .memWrite      (memWrite),
    .regWrite      (regWrite),
    .writeRegFrom  (writeRegFrom),
    .laneMask      (laneMask),
    .address       (address),
    .imm           (imm),
    .destReg       (destReg),
    .writeData     (writeData),
    .aluResult     (aluResult),
    .outValid      (outValid),
    .outReady      (outReady),
    .writeBackData (writeBackData),
    .rfWriteEnable (rfWriteEnable),
    .rfDest        (rfDest),
    .addrError     (addrError)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;
  int last_acc = 0;
  int last_out = 0;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting, expected event within bound (cycle %0d)", name, cycle);
  endtask

  // Reference model: each accepted op becomes a queue entry carrying its result and earliest output cycle.
  typedef struct {
    logic [DW-1:0] data;
    logic          rfwe;
    logic [RW-1:0] dest;
    logic          err;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mmem [DEPTH];
  int            clear_left = DEPTH;
  bit            armed = 1'b0;

  always @(negedge clk) begin
    logic exp_valid;
    logic exp_ready;
    exp_t e;
    int   a;
    exp_valid = armed && (q.size() > 0) && (q[0].due <= cycle);
    exp_ready = armed && (clear_left == 0) && !(exp_valid && !outReady);
    if (armed) begin
      check("outValid", 64'(outValid), 64'(exp_valid));
      check("inReady", 64'(inReady), 64'(exp_ready));
      if (exp_valid) begin
        check("writeBackData", 64'(writeBackData), 64'(q[0].data));
        check("rfWriteEnable", 64'(rfWriteEnable), 64'(q[0].rfwe));
        check("rfDest", 64'(rfDest), 64'(q[0].dest));
        check("addrError", 64'(addrError), 64'(q[0].err));
      end
    end
    if (!reset) begin
      q.delete();
      for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
      clear_left = DEPTH;
      armed = 1'b1;
    end else begin
      if (clear_left > 0) clear_left--;
      if (exp_valid && outReady) void'(q.pop_front());
      if (inValid && exp_ready) begin
        a = int'(address);
        case (writeRegFrom)
          2'd0:    e.data = (a < DEPTH) ? mmem[a] : '0;
          2'd1:    e.data = aluResult;
          2'd2:    e.data = {VS{imm}};
          default: e.data = '0;
        endcase
        e.rfwe = regWrite && (writeRegFrom != 2'd3);
        e.dest = destReg;
        e.err  = (a >= DEPTH);
        e.due  = cycle + 2;
        q.push_back(e);
        if (memWrite && a < DEPTH) begin
          for (int i = 0; i < VS; i++) begin
            if (laneMask[i]) mmem[a][i*RS +: RS] = writeData[i*RS +: RS];
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic mw, input logic rw, input logic [1:0] src, input logic [VS-1:0] mask,
                      input logic [RS-1:0] addr, input logic [RS-1:0] im, input logic [RW-1:0] dst,
                      input logic [DW-1:0] wd, input logic [DW-1:0] alu);
    int waited = 0;
    memWrite = mw; regWrite = rw; writeRegFrom = src; laneMask = mask;
    address = addr; imm = im; destReg = dst; writeData = wd; aluResult = alu;
    inValid = 1'b1;
    forever begin
      @(negedge clk);
      if (inReady === 1'b1) begin
        last_acc = cycle;
        break;
      end
      waited++;
      if (waited > 200) begin
        timeout_fail("send_accept");
        break;
      end
    end
    tick();
    inValid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [DW-1:0] d, input logic rfwe,
                            input logic [RW-1:0] dst, input logic err);
    int waited = 0;
    forever begin
      @(negedge clk);
      if (outValid === 1'b1) break;
      waited++;
      if (waited > 50) begin
        timeout_fail(name);
        tick();
        return;
      end
    end
    last_out = cycle;
    check({name, "_data"}, 64'(writeBackData), 64'(d));
    check({name, "_rfwe"}, 64'(rfWriteEnable), 64'(rfwe));
    check({name, "_dest"}, 64'(rfDest), 64'(dst));
    check({name, "_err"}, 64'(addrError), 64'(err));
    tick();
  endtask

  task automatic count_clear(input string name);
    int n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (inReady === 1'b1) break;
      n++;
    end
    check(name, 64'(n), 64'(32));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; inValid = 1'b0; memWrite = 1'b0; regWrite = 1'b0; writeRegFrom = 2'd0;
    laneMask = '0; address = '0; imm = '0; destReg = '0; writeData = '0; aluResult = '0;
    outReady = 1'b1;
    repeat (2) tick();
    check("reset_outValid", 64'(outValid), 64'(0));
    check("reset_inReady", 64'(inReady), 64'(0));
    reset = 1'b1;
    count_clear("clear_cycles");

    send(1'b0, 1'b1, 2'd0, 4'h0, 8'd0, 8'h00, 4'd1, 32'h0, 32'h0);
    expect_out("t1_read0", 32'h00000000, 1'b1, 4'd1, 1'b0);
    check("t1_latency", 64'(last_out - last_acc), 64'(2));

    send(1'b1, 1'b0, 2'd3, 4'hF, 8'd4, 8'h00, 4'd0, 32'hDEADBEEF, 32'h0);
    send(1'b0, 1'b1, 2'd0, 4'h0, 8'd4, 8'h00, 4'd5, 32'h0, 32'h0);
    expect_out("t2_store", 32'h0, 1'b0, 4'd0, 1'b0);
    expect_out("t2_read", 32'hDEADBEEF, 1'b1, 4'd5, 1'b0);

    send(1'b1, 1'b0, 2'd3, 4'b0101, 8'd4, 8'h00, 4'd0, 32'h11223344, 32'h0);
    send(1'b0, 1'b1, 2'd0, 4'h0, 8'd4, 8'h00, 4'd6, 32'h0, 32'h0);
    expect_out("t3_store", 32'h0, 1'b0, 4'd0, 1'b0);
    expect_out("t3_read", 32'hDE22BE44, 1'b1, 4'd6, 1'b0);

    outReady = 1'b0;
    send(1'b0, 1'b1, 2'd2, 4'h0, 8'd0, 8'hFE, 4'd7, 32'h0, 32'h0);
    send(1'b0, 1'b1, 2'd1, 4'h0, 8'd0, 8'h00, 4'd8, 32'h0, 32'hCAFEBABE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 64'(outValid), 64'(1));
      check("t4_hold_data", 64'(writeBackData), 64'(32'hFEFEFEFE));
      check("t4_hold_inReady", 64'(inReady), 64'(0));
    end
    tick();
    outReady = 1'b1;
    @(negedge clk);
    check("t4_release_imm", 64'(writeBackData), 64'(32'hFEFEFEFE));
    @(negedge clk);
    check("t4_alu_valid", 64'(outValid), 64'(1));
    check("t4_alu_data", 64'(writeBackData), 64'(32'hCAFEBABE));
    @(negedge clk);
    check("t4_no_dup", 64'(outValid), 64'(0));
    tick();

    send(1'b0, 1'b1, 2'd0, 4'h0, 8'd40, 8'h00, 4'd2, 32'h0, 32'h0);
    expect_out("t5_read40", 32'h0, 1'b1, 4'd2, 1'b1);
    send(1'b1, 1'b1, 2'd3, 4'hF, 8'd40, 8'h00, 4'd3, 32'hFFFFFFFF, 32'h0);
    expect_out("t5_store40_none", 32'h0, 1'b0, 4'd3, 1'b1);
    send(1'b0, 1'b1, 2'd0, 4'h0, 8'd8, 8'h00, 4'd4, 32'h0, 32'h0);
    expect_out("t5_read8", 32'h0, 1'b1, 4'd4, 1'b0);

    for (int i = 0; i < 400; i++) begin
      inValid      = ($urandom_range(0, 9) < 7);
      outReady     = ($urandom_range(0, 3) != 0);
      memWrite     = $urandom_range(0, 1) != 0;
      regWrite     = $urandom_range(0, 1) != 0;
      writeRegFrom = 2'($urandom_range(0, 3));
      laneMask     = 4'($urandom_range(0, 15));
      address      = 8'($urandom_range(0, 47));
      imm          = 8'($urandom);
      destReg      = 4'($urandom_range(0, 15));
      writeData    = $urandom;
      aluResult    = $urandom;
      tick();
    end
    inValid = 1'b0;
    outReady = 1'b1;
    repeat (5) tick();

    send(1'b0, 1'b1, 2'd1, 4'h0, 8'd0, 8'h00, 4'd9, 32'h0, 32'h12345678);
    send(1'b0, 1'b1, 2'd1, 4'h0, 8'd0, 8'h00, 4'd10, 32'h0, 32'h9ABCDEF0);
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("t6_flush_outValid", 64'(outValid), 64'(0));
    check("t6_flush_inReady", 64'(inReady), 64'(0));
    tick();
    reset = 1'b1;
    count_clear("t6_clear_cycles");
    send(1'b0, 1'b1, 2'd0, 4'h0, 8'd4, 8'h00, 4'd11, 32'h0, 32'h0);
    expect_out("t6_read4", 32'h0, 1'b1, 4'd11, 1'b0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
